// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: per-operand forwarding select and stall generation for the
// ID/EX instruction, plus a fixed-latency MUL/DIV scoreboard and stall counter.
module fwd_hazard_unit #(
    parameter int ADDR_W     = 5,
    parameter int NUM_STAGES = 2,
    parameter int MC_LAT     = 4,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         id_valid,
    input  logic [ADDR_W-1:0]            id_rs1,
    input  logic [ADDR_W-1:0]            id_rs2,
    input  logic                         id_use_rs1,
    input  logic                         id_use_rs2,
    input  logic [ADDR_W-1:0]            id_rd,
    input  logic                         id_wr_en,
    input  logic                         id_mc_issue,
    input  logic [NUM_STAGES-1:0]        stg_wr_en,
    input  logic [NUM_STAGES*ADDR_W-1:0] stg_dest,
    input  logic [NUM_STAGES-1:0]        stg_data_ready,
    output logic [SEL_W-1:0]             fa_sel,
    output logic [SEL_W-1:0]             fb_sel,
    output logic                         stall,
    output logic                         mc_busy,
    output logic [31:0]                  stall_cycles
);

    localparam int               CNT_W   = $clog2(MC_LAT + 1);
    localparam logic [CNT_W-1:0] LAT     = CNT_W'(MC_LAT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [31:0]      CNT_MAX = 32'hFFFF_FFFF;

    logic [CNT_W-1:0]  mc_cnt_q;
    logic [CNT_W-1:0]  mc_cnt_d;
    logic [ADDR_W-1:0] mc_dest_q;
    logic [ADDR_W-1:0] mc_dest_d;
    logic [31:0]       stall_cnt_q;
    logic [31:0]       stall_cnt_d;

    logic [ADDR_W-1:0] src_addr [2];
    logic [SEL_W-1:0]  src_sel  [2];
    logic [1:0]        src_use;
    logic [1:0]        src_live;
    logic [1:0]        src_hit;
    logic [1:0]        fwd_haz;
    logic [1:0]        sb_haz;

    logic busy;
    logic dest_nz;
    logic waw_haz;
    logic struct_haz;
    logic stall_w;
    logic issue_ok;

    assign src_addr[0] = id_rs1;
    assign src_addr[1] = id_rs2;
    assign src_use     = {id_use_rs2, id_use_rs1};

    assign busy    = (mc_cnt_q != '0);
    assign dest_nz = (mc_dest_q != '0);

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_live[s] = id_valid & src_use[s] & (src_addr[s] != '0);
        end
    end

    // Scan youngest to oldest; the first matching writer decides, even when
    // its data is not ready yet (an older copy would be stale).
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_hit[s] = 1'b0;
            fwd_haz[s] = 1'b0;
            src_sel[s] = '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (!src_hit[s] && stg_wr_en[k] &&
                    (stg_dest[k*ADDR_W +: ADDR_W] == src_addr[s])) begin
                    src_hit[s] = 1'b1;
                    if (stg_data_ready[k]) begin
                        src_sel[s] = SEL_W'(k + 1);
                    end else begin
                        fwd_haz[s] = 1'b1;
                    end
                end
            end
            if (!src_live[s]) begin
                src_sel[s] = '0;
                fwd_haz[s] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            sb_haz[s] = src_live[s] & busy & dest_nz &
                        (src_addr[s] == mc_dest_q);
        end
    end

    assign waw_haz    = id_valid & id_wr_en & busy & dest_nz &
                        (id_rd == mc_dest_q);
    assign struct_haz = id_valid & id_mc_issue & busy;

    assign stall_w  = (|fwd_haz) | (|sb_haz) | waw_haz | struct_haz;
    assign issue_ok = id_valid & id_mc_issue & ~stall_w;

    always_comb begin
        mc_cnt_d  = mc_cnt_q;
        mc_dest_d = mc_dest_q;
        if (issue_ok) begin
            mc_cnt_d  = LAT;
            mc_dest_d = id_wr_en ? id_rd : '0;
        end else if (busy) begin
            mc_cnt_d = mc_cnt_q - ONE;
            if (mc_cnt_q == ONE) begin
                mc_dest_d = '0;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_w && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mc_cnt_q    <= '0;
            mc_dest_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            mc_cnt_q    <= mc_cnt_d;
            mc_dest_q   <= mc_dest_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fa_sel       = stall_w ? '0 : src_sel[0];
    assign fb_sel       = stall_w ? '0 : src_sel[1];
    assign stall        = stall_w;
    assign mc_busy      = busy;
    assign stall_cycles = stall_cnt_q;

endmodule
